ram_sp_arb: RTL and testbench

- Two-requester arbiter that shares one single-port synchronous RAM (`ram_if_sp`-style: a/d/w in, q out, 1-cycle read latency).
- Fair round-robin grant; one command issued per cycle; registered command stage to the RAM.
- Read data is returned to the originating requester with a valid strobe, using a tag pipeline.
- Sits between system masters (e.g. a packet engine and a CPU/debug port) and the RAM macro.

---
 rtl/ram_sp_arb.sv | 177 +++++++++++++++++
 tb/tb_ram_sp_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arb.sv
// ---------------------------------------------------------------------------
// ram_sp_arb
//
// Shares one single-port synchronous RAM (1-cycle read latency) between two
// requesters. Grants are fair round-robin with no idle cycles. One command
// is issued per cycle through a registered command stage. Read data is
// steered back to the originating requester by a small tag pipeline that
// carries {read valid, requester id} alongside the RAM access.
//
// Optional build macro: RAM_ARB_QREG_EN
//   undefined : read data returns at accept+2 and rX_q is a combinational
//               passthrough of ram_q (meaningful only while rX_qv=1)
//   defined   : an extra output register on rX_q/rX_qv, so read data returns
//               at accept+3 and each rX_q holds its last returned value
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rX_v, rX_w, rX_a, rX_d   requester X command: valid, write, addr, wdata
//   rX_rdy                   requester X command accepted this cycle
//   rX_qv, rX_q              requester X read-data valid strobe and data
//   ram_a, ram_d, ram_w      registered RAM command
//   ram_q                    RAM read data (1 cycle after ram_a)
// ---------------------------------------------------------------------------
module ram_sp_arb #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_v,
    input  logic          r0_w,
    input  logic [AW-1:0] r0_a,
    input  logic [DW-1:0] r0_d,
    output logic          r0_rdy,
    output logic          r0_qv,
    output logic [DW-1:0] r0_q,

    input  logic          r1_v,
    input  logic          r1_w,
    input  logic [AW-1:0] r1_a,
    input  logic [DW-1:0] r1_d,
    output logic          r1_rdy,
    output logic          r1_qv,
    output logic [DW-1:0] r1_q,

    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_w,
    input  logic [DW-1:0] ram_q
);

    // Round-robin pointer: index of the requester granted most recently.
    logic          last_q, last_d;

    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_w_q, ram_w_d;

    // Tag pipeline: _p1 is aligned with the RAM command, _p2 with ram_q.
    logic          rd_vld_p1_q, rd_vld_p1_d;
    logic          rd_id_p1_q,  rd_id_p1_d;
    logic          rd_vld_p2_q, rd_vld_p2_d;
    logic          rd_id_p2_q,  rd_id_p2_d;

    logic          gnt0;
    logic          gnt1;

    // Grant: a lone requester always wins; on contention the requester that
    // was not granted last wins.
    always_comb begin
        gnt0 = r0_v & (~r1_v | last_q);
        gnt1 = r1_v & (~r0_v | ~last_q);
    end

    assign r0_rdy = gnt0;
    assign r1_rdy = gnt1;

    always_comb begin
        last_d      = last_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        ram_w_d     = 1'b0;
        rd_vld_p1_d = 1'b0;
        rd_id_p1_d  = 1'b0;

        if (gnt0) begin
            last_d      = 1'b0;
            ram_a_d     = r0_a;
            ram_d_d     = r0_d;
            ram_w_d     = r0_w;
            rd_vld_p1_d = ~r0_w;
            rd_id_p1_d  = 1'b0;
        end else if (gnt1) begin
            last_d      = 1'b1;
            ram_a_d     = r1_a;
            ram_d_d     = r1_d;
            ram_w_d     = r1_w;
            rd_vld_p1_d = ~r1_w;
            rd_id_p1_d  = 1'b1;
        end

        rd_vld_p2_d = rd_vld_p1_q;
        rd_id_p2_d  = rd_id_p1_q;
    end

    // ---- stage p1: registered RAM command + tag --------------------------
    // ---- stage p2: tag aligned with ram_q --------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= 1'b1;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            ram_w_q     <= 1'b0;
            rd_vld_p1_q <= 1'b0;
            rd_id_p1_q  <= 1'b0;
            rd_vld_p2_q <= 1'b0;
            rd_id_p2_q  <= 1'b0;
        end else begin
            last_q      <= last_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            ram_w_q     <= ram_w_d;
            rd_vld_p1_q <= rd_vld_p1_d;
            rd_id_p1_q  <= rd_id_p1_d;
            rd_vld_p2_q <= rd_vld_p2_d;
            rd_id_p2_q  <= rd_id_p2_d;
        end
    end

    assign ram_a = ram_a_q;
    assign ram_d = ram_d_q;
    assign ram_w = ram_w_q;

`ifdef RAM_ARB_QREG_EN
    logic          r0_qv_p3_q, r0_qv_p3_d;
    logic          r1_qv_p3_q, r1_qv_p3_d;
    logic [DW-1:0] r0_q_p3_q,  r0_q_p3_d;
    logic [DW-1:0] r1_q_p3_q,  r1_q_p3_d;

    // Each requester's data register only loads on its own return, so it
    // holds the last value it received.
    always_comb begin
        r0_qv_p3_d = rd_vld_p2_q & ~rd_id_p2_q;
        r1_qv_p3_d = rd_vld_p2_q &  rd_id_p2_q;
        r0_q_p3_d  = r0_qv_p3_d ? ram_q : r0_q_p3_q;
        r1_q_p3_d  = r1_qv_p3_d ? ram_q : r1_q_p3_q;
    end

    // ---- stage p3: registered read return --------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_qv_p3_q <= 1'b0;
            r1_qv_p3_q <= 1'b0;
            r0_q_p3_q  <= '0;
            r1_q_p3_q  <= '0;
        end else begin
            r0_qv_p3_q <= r0_qv_p3_d;
            r1_qv_p3_q <= r1_qv_p3_d;
            r0_q_p3_q  <= r0_q_p3_d;
            r1_q_p3_q  <= r1_q_p3_d;
        end
    end

    assign r0_qv = r0_qv_p3_q;
    assign r1_qv = r1_qv_p3_q;
    assign r0_q  = r0_q_p3_q;
    assign r1_q  = r1_q_p3_q;
`else
    // Read data is broadcast; only the strobe is steered by the tag.
    assign r0_qv = rd_vld_p2_q & ~rd_id_p2_q;
    assign r1_qv = rd_vld_p2_q &  rd_id_p2_q;
    assign r0_q  = ram_q;
    assign r1_q  = ram_q;
`endif

endmodule

// File: tb/tb_ram_sp_arb.sv
module tb_ram_sp_arb;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef RAM_ARB_QREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    typedef struct packed {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_v, r0_w, r0_rdy, r0_qv;
    logic [AW-1:0] r0_a;
    logic [DW-1:0] r0_d, r0_q;
    logic          r1_v, r1_w, r1_rdy, r1_qv;
    logic [AW-1:0] r1_a;
    logic [DW-1:0] r1_d, r1_q;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_w;
    logic [DW-1:0] ram_q;

    // RAM model and its back-door preload port
    logic [DW-1:0] mem [0:255];
    logic          ram_init;
    logic          pre_en;
    logic [7:0]    pre_a;
    logic [DW-1:0] pre_d;

    cmd_t cq0[$], cq1[$];        // stimulus per requester
    exp_t eq0[$], eq1[$];        // expected read returns per requester
    logic acc0 = 1'b0, acc1 = 1'b0;
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    int   tmo_cnt = 0, tmo_seen = 0;

    ram_sp_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_v(r0_v), .r0_w(r0_w), .r0_a(r0_a), .r0_d(r0_d),
        .r0_rdy(r0_rdy), .r0_qv(r0_qv), .r0_q(r0_q),
        .r1_v(r1_v), .r1_w(r1_w), .r1_a(r1_a), .r1_d(r1_d),
        .r1_rdy(r1_rdy), .r1_qv(r1_qv), .r1_q(r1_q),
        .ram_a(ram_a), .ram_d(ram_d), .ram_w(ram_w), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 771) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (pre_en) mem[pre_a] <= pre_d;
            if (ram_w) mem[ram_a[7:0]] <= ram_d;
        end
        ram_q <= mem[ram_a[7:0]];
    end

    function automatic cmd_t rd(input logic [AW-1:0] a);
        return '{v: 1'b1, w: 1'b0, a: a, d: DW'($urandom)};
    endfunction
    function automatic cmd_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return '{v: 1'b1, w: 1'b1, a: a, d: d};
    endfunction

    // ------------------------------------------------------------------
    // Driver: a requester keeps its command until accepted, then moves on.
    // ------------------------------------------------------------------
    initial begin
        cmd_t c;
        r0_v = 0; r0_w = 0; r0_a = '0; r0_d = '0;
        r1_v = 0; r1_w = 0; r1_a = '0; r1_d = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!r0_v || acc0) begin
                if (cq0.size() > 0) begin
                    c = cq0.pop_front();
                    r0_v = c.v; r0_w = c.w; r0_a = c.a; r0_d = c.d;
                end else r0_v = 1'b0;
            end
            if (!r1_v || acc1) begin
                if (cq1.size() > 0) begin
                    c = cq1.pop_front();
                    r1_v = c.v; r1_w = c.w; r1_a = c.a; r1_d = c.d;
                end else r1_v = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checker: reference model (pushes expectations) and monitor (pops).
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    logic [DW-1:0] ref_mem [0:255];
    int            last_gnt;
    logic          exp_w;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;

    task automatic monitor_one(input string nm, input logic qv, input logic [DW-1:0] q,
                               inout exp_t eq[$]);
        exp_t e;
        if (qv) begin
            if (eq.size() == 0) chk({nm, "_qv_unexpected"}, 32'(qv), 32'd0);
            else begin
                e = eq.pop_front();
                chk({nm, "_qv_cycle"}, 32'(cyc), 32'(e.due));
                chk({nm, "_q"}, 32'(q), 32'(e.d));
            end
        end else if (eq.size() > 0 && eq[0].due <= cyc) begin
            e = eq.pop_front();
            chk({nm, "_qv_missing"}, 32'(qv), 32'd1);
        end
    endtask

    task automatic model_step();
        int win;
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        // command accepted last cycle must be on the RAM port now
        chk("ram_w", 32'(ram_w), 32'(exp_w));
        chk("ram_a", 32'(ram_a), 32'(exp_a));
        chk("ram_d", 32'(ram_d), 32'(exp_d));
        if (r0_v && r1_v) win = (last_gnt == 0) ? 1 : 0;
        else if (r0_v)    win = 0;
        else if (r1_v)    win = 1;
        else              win = -1;
        chk("r0_rdy", 32'(r0_rdy), 32'(win == 0));
        chk("r1_rdy", 32'(r1_rdy), 32'(win == 1));
        exp_w = 1'b0;
        if (win >= 0) begin
            last_gnt = win;
            w = (win == 0) ? r0_w : r1_w;
            a = (win == 0) ? r0_a : r1_a;
            d = (win == 0) ? r0_d : r1_d;
            exp_w = w; exp_a = a; exp_d = d;
            if (w) ref_mem[a[7:0]] = d;
            else if (win == 0) eq0.push_back('{due: cyc + LAT, d: ref_mem[a[7:0]]});
            else               eq1.push_back('{due: cyc + LAT, d: ref_mem[a[7:0]]});
        end
        acc0 = r0_v & r0_rdy;
        acc1 = r1_v & r1_rdy;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        last_gnt = 1; exp_w = 1'b0; exp_a = '0; exp_d = '0;
        forever begin
            @(negedge clk);
            if (tmo_cnt != tmo_seen) begin
                n_vec++; n_err++;
                $display("FAIL drain_timeout: pending work after cycle budget, required none");
                tmo_seen = tmo_cnt;
            end
            if (pre_en) ref_mem[pre_a] = pre_d;
            if (rst) begin
                chk("rst_ram_w", 32'(ram_w), 32'd0);
                chk("rst_ram_a", 32'(ram_a), 32'd0);
                chk("rst_ram_d", 32'(ram_d), 32'd0);
                chk("rst_r0_qv", 32'(r0_qv), 32'd0);
                chk("rst_r1_qv", 32'(r1_qv), 32'd0);
`ifdef RAM_ARB_QREG_EN
                chk("rst_r0_q", 32'(r0_q), 32'd0);
                chk("rst_r1_q", 32'(r1_q), 32'd0);
`endif
                eq0.delete(); eq1.delete();
                last_gnt = 1; exp_w = 1'b0; exp_a = '0; exp_d = '0;
                acc0 = 1'b0; acc1 = 1'b0;
            end else begin
                monitor_one("r0", r0_qv, r0_q, eq0);
                monitor_one("r1", r1_qv, r1_q, eq1);
                model_step();
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drain();
        int n = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 || r0_v || r1_v ||
                eq0.size() > 0 || eq1.size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) tmo_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; ram_init = 1'b0; pre_en = 1'b0; pre_a = '0; pre_d = '0;
        @(posedge clk); #1 ram_init = 1'b1;
        @(posedge clk); #1 ram_init = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // single read
        preload(8'h10, 16'hBEEF);
        cq0.push_back(rd(16'h0010));
        drain();

        // write then read, same requester
        cq1.push_back(wr(16'h0020, 16'h1234));
        cq1.push_back(rd(16'h0020));
        drain();

        // contention: both requesters stream 4 reads each
        for (int i = 0; i < 4; i++) begin
            cq0.push_back(rd(AW'(16'h0040 + i)));
            cq1.push_back(rd(AW'(16'h0050 + i)));
        end
        drain();

        // lone requester streaming
        for (int i = 0; i < 5; i++) cq1.push_back(rd(AW'(16'h0060 + i)));
        drain();

        // idle hold after a write
        cq0.push_back(wr(16'h0030, 16'hCAFE));
        drain();
        repeat (4) @(negedge clk);

        // reset one cycle after a read is accepted
        cq0.push_back(rd(16'h0044));
        n = 0;
        while (!acc0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo_cnt++;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        cq0.push_back(rd(16'h0010));
        cq1.push_back(rd(16'h0020));
        drain();

        // randomized traffic with bubbles over a small address window
        for (int i = 0; i < 200; i++) begin
            cmd_t c;
            c.v = ($urandom_range(0, 3) != 0);
            c.w = 1'($urandom_range(0, 1));
            c.a = AW'($urandom_range(0, 15));
            c.d = DW'($urandom);
            cq0.push_back(c);
            c.v = ($urandom_range(0, 3) != 0);
            c.w = 1'($urandom_range(0, 1));
            c.a = AW'($urandom_range(0, 15));
            c.d = DW'($urandom);
            cq1.push_back(c);
        end
        drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
